// File: rtl/imem_line_responder.sv
// rtl/imem_line_responder.sv - instruction-cache line-fill responder: fixed latency, four 32-bit beats per 16-byte line
// Optional IMEM_RANGE_ERR_EN: out-of-range requests return zero data with resp_err; out-of-range init writes are dropped.
module imem_line_responder #(
    parameter int MEM_BYTES = 256,
    parameter int LATENCY   = 3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_beat,
    output logic        resp_last,
    output logic        resp_err,
    input  logic        init_we,
    input  logic [63:0] init_addr,
    input  logic [31:0] init_data
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   line_addr_q, line_addr_d;
    logic [1:0]      beat_q, beat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [7:0]      mem_q [MEM_BYTES];
    logic [7:0]      mem_d [MEM_BYTES];

    logic            req_fire;
    logic            resp_fire;
    logic            req_oor;
    logic            init_oor;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     rd_word;
    logic            unused_bits;

`ifdef IMEM_RANGE_ERR_EN
    assign req_oor  = |req_addr[63:AW];
    assign init_oor = |init_addr[63:AW];
`else
    assign req_oor  = 1'b0;
    assign init_oor = 1'b0;
`endif

    assign unused_bits = ^{req_addr[63:AW], req_addr[3:0], init_addr[63:AW], init_addr[1:0]};

    assign req_fire  = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;

    // Line base has zero low nibble, so beat offsets never carry out of the line.
    assign rd_addr = line_addr_q + AW'({beat_q, 2'b00});
    assign wr_addr = {init_addr[AW-1:2], 2'b00};
    assign rd_word = {mem_q[{rd_addr[AW-1:2], 2'd3}], mem_q[{rd_addr[AW-1:2], 2'd2}],
                      mem_q[{rd_addr[AW-1:2], 2'd1}], mem_q[{rd_addr[AW-1:2], 2'd0}]};

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    line_addr_d = {req_addr[AW-1:4], 4'h0};
                    beat_d      = 2'd0;
                    err_d       = req_oor;
                    if (LATENCY == 0) begin
                        state_d = BURST;
                    end else begin
                        cnt_d   = CW'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = BURST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            BURST: begin
                if (resp_fire) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by reset so an aborted burst shows nothing while reset is high.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    req_ready  = 1'b1;
                BURST:   resp_valid = 1'b1;
                default: ;
            endcase
        end
        resp_beat = resp_valid ? beat_q : 2'd0;
        resp_last = resp_valid && (beat_q == 2'd3);
        resp_err  = resp_valid && err_q;
        resp_data = err_q ? 32'h0 : rd_word;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            line_addr_q <= '0;
            beat_q      <= 2'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            line_addr_q <= line_addr_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (init_we && !init_oor) begin
            mem_d[{wr_addr[AW-1:2], 2'd0}] = init_data[7:0];
            mem_d[{wr_addr[AW-1:2], 2'd1}] = init_data[15:8];
            mem_d[{wr_addr[AW-1:2], 2'd2}] = init_data[23:16];
            mem_d[{wr_addr[AW-1:2], 2'd3}] = init_data[31:24];
        end
    end

    // Reset image: word 0 holds addi x1,x1,5, everything else is zero.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
            mem_q[0] <= 8'h93;
            mem_q[1] <= 8'h80;
            mem_q[2] <= 8'h50;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule
